nios2_ocimem_arbiter: RTL and testbench

- Sequences the Nios II on-chip debug memory (OCI RAM), a single-port 32-bit RAM with 1-cycle read latency, and shares it between two requesters.
- Requester 1 is the debug-slave JTAG command path: jdo plus the take_action_ocimem_* strobes, already in the sysclk domain.
- Requester 2 is the CPU debug Avalon slave port.
- Returns JTAG read data in MonDReg and keeps the auto-incrementing monitor address MonAReg.

---
 rtl/nios2_ocimem_pkg.sv | 22 ++
 rtl/nios2_ocimem_jtag_cmd.sv | 82 ++++++++
 rtl/nios2_ocimem_arbiter.sv | 121 ++++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_ocimem_pkg.sv
// Shared definitions for the Nios II OCI RAM sequencer/arbiter.
//   state_e : arbiter FSM states (IDLE, JRD = JTAG read data, CRD = CPU read data)
//   grant_e : which requester received the most recent RAM grant
//   JDO_*   : field positions inside the 38-bit JTAG command word
package nios2_ocimem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      JRD  = 2'd1,
      CRD  = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_CPU  = 1'b0,
      GRANT_JTAG = 1'b1
   } grant_e;

   localparam int unsigned JDO_WR_BIT   = 35;
   localparam int unsigned JDO_ADDR_LSB = 2;
   localparam int unsigned JDO_DATA_MSB = 31;

endpackage

// File: rtl/nios2_ocimem_jtag_cmd.sv
// JTAG command capture for the OCI RAM.
// Holds a single pending JTAG operation (jpend, op_write, wdata), owns the
// auto-incrementing monitor address MonAReg and the sticky overrun flag.
//   clk, reset_n        : clock, asynchronous active-low reset
//   jdo                 : JTAG command/data word
//   take_*              : one-cycle command strobes
//   in_jrd              : arbiter is returning JTAG read data this cycle
//   done                : the pending JTAG access completes this cycle
//   jpend               : an operation is queued (or in its read-data cycle)
//   op_write, wdata     : queued operation type and write data
//   MonAReg             : monitor address
//   jtag_overrun        : sticky, a strobe arrived while busy
module nios2_ocimem_jtag_cmd
   import nios2_ocimem_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned RAM_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              in_jrd,
   input  logic              done,
   output logic              jpend,
   output logic              op_write,
   output logic [31:0]       wdata,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              jtag_overrun
);

   logic              op_incr;
   logic              any_strobe;
   logic              busy;
   logic [ADDR_W-1:0] mona_next;
   logic              unused_jdo;

   assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign busy       = jpend | in_jrd;
   // Explicit wrap so the increment stays correct against the RAM depth.
   assign mona_next  = (MonAReg == ADDR_W'(RAM_WORDS - 1)) ? '0 : MonAReg + 1'b1;
   assign unused_jdo = ^{jdo[37:36], jdo[34:32]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jpend        <= 1'b0;
         op_write     <= 1'b0;
         op_incr      <= 1'b0;
         wdata        <= '0;
         MonAReg      <= '0;
         jtag_overrun <= 1'b0;
      end else begin
         // done implies busy, so completion and acceptance never coincide.
         if (done) begin
            jpend <= 1'b0;
            if (op_incr) MonAReg <= mona_next;
         end
         if (any_strobe) begin
            if (busy) begin
               jtag_overrun <= 1'b1;
            end else if (take_action_ocimem_a) begin
               MonAReg  <= jdo[JDO_ADDR_LSB + ADDR_W - 1 : JDO_ADDR_LSB];
               jpend    <= 1'b1;
               op_write <= 1'b0;
               op_incr  <= 1'b0;
            end else if (take_no_action_ocimem_a) begin
               jpend    <= 1'b1;
               op_write <= 1'b0;
               op_incr  <= 1'b0;
            end else begin
               jpend    <= 1'b1;
               op_write <= jdo[JDO_WR_BIT];
               wdata    <= jdo[JDO_DATA_MSB:0];
               op_incr  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Nios II OCI RAM sequencer: shares a single-port 1-cycle-latency RAM between
// the JTAG command path and the CPU Avalon debug slave, alternating grants
// under contention.
//   clk, reset_n          : clock, asynchronous active-low reset
//   jdo, take_*           : JTAG command word and strobes
//   cpu_*                 : Avalon slave (address, read, write, data, waitrequest)
//   ram_*                 : RAM address/write/byte-enable/data, ram_rdata 1 cycle late
//   MonDReg, MonAReg      : JTAG read-back data and monitor address
//   jtag_busy             : JTAG op pending or in flight
//   jtag_overrun          : sticky overrun flag
module nios2_ocimem_arbiter
   import nios2_ocimem_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned RAM_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   input  logic [3:0]        cpu_byteenable,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [3:0]        ram_be,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              jtag_busy,
   output logic              jtag_overrun
);

   state_e      state;
   grant_e      last_grant;
   logic        jpend;
   logic        jop_write;
   logic [31:0] jwdata;
   logic        cpu_req;
   logic        grant_jtag;
   logic        grant_cpu;
   logic        in_jrd;
   logic        jdone;

   nios2_ocimem_jtag_cmd #(
      .ADDR_W   (ADDR_W),
      .RAM_WORDS(RAM_WORDS)
   ) u_jtag_cmd (
      .clk                    (clk),
      .reset_n                (reset_n),
      .jdo                    (jdo),
      .take_action_ocimem_a   (take_action_ocimem_a),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .take_action_ocimem_b   (take_action_ocimem_b),
      .in_jrd                 (in_jrd),
      .done                   (jdone),
      .jpend                  (jpend),
      .op_write               (jop_write),
      .wdata                  (jwdata),
      .MonAReg                (MonAReg),
      .jtag_overrun           (jtag_overrun)
   );

   // Arbitration happens only in IDLE; ties go to whoever was not served last.
   always_comb begin
      cpu_req    = cpu_read | cpu_write;
      grant_jtag = 1'b0;
      grant_cpu  = 1'b0;
      if (state == IDLE) begin
         if (jpend && (!cpu_req || last_grant == GRANT_CPU)) grant_jtag = 1'b1;
         else if (cpu_req)                                    grant_cpu  = 1'b1;
      end
   end

   assign in_jrd = (state == JRD);
   assign jdone  = (grant_jtag & jop_write) | in_jrd;

   always_comb begin
      ram_addr        = (grant_cpu || state == CRD) ? cpu_address : MonAReg;
      ram_we          = (grant_jtag & jop_write) | (grant_cpu & cpu_write);
      ram_be          = grant_cpu ? cpu_byteenable : '1;
      ram_wdata       = grant_cpu ? cpu_writedata : jwdata;
      cpu_waitrequest = ~((grant_cpu & cpu_write) | (state == CRD));
      cpu_readdata    = (state == CRD) ? ram_rdata : '0;
      jtag_busy       = jpend | in_jrd;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= GRANT_CPU;
         MonDReg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_jtag) begin
                  last_grant <= GRANT_JTAG;
                  if (!jop_write) state <= JRD;
               end else if (grant_cpu) begin
                  last_grant <= GRANT_CPU;
                  if (!cpu_write) state <= CRD;
               end
            end
            JRD: begin
               MonDReg <= ram_rdata;
               state   <= IDLE;
            end
            CRD:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Self-checking bench for nios2_ocimem_arbiter: a RAM attached to the DUT,
// a transaction-level reference model (shadow memory, monitor address,
// last-served requester), table vectors, directed corner cases and a
// randomized phase.
module tb_nios2_ocimem_arbiter;

   logic        clk;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_no_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic [7:0]  cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_writedata;
   logic [3:0]  cpu_byteenable;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] MonDReg;
   logic [7:0]  MonAReg;
   logic        jtag_busy;
   logic        jtag_overrun;

   nios2_ocimem_arbiter #(
      .ADDR_W   (8),
      .RAM_WORDS(256)
   ) dut (
      .clk                    (clk),
      .reset_n                (reset_n),
      .jdo                    (jdo),
      .take_action_ocimem_a   (take_action_ocimem_a),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .take_action_ocimem_b   (take_action_ocimem_b),
      .cpu_address            (cpu_address),
      .cpu_read               (cpu_read),
      .cpu_write              (cpu_write),
      .cpu_writedata          (cpu_writedata),
      .cpu_byteenable         (cpu_byteenable),
      .cpu_readdata           (cpu_readdata),
      .cpu_waitrequest        (cpu_waitrequest),
      .ram_addr               (ram_addr),
      .ram_we                 (ram_we),
      .ram_be                 (ram_be),
      .ram_wdata              (ram_wdata),
      .ram_rdata              (ram_rdata),
      .MonDReg                (MonDReg),
      .MonAReg                (MonAReg),
      .jtag_busy              (jtag_busy),
      .jtag_overrun           (jtag_overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] pat(input int unsigned i);
      logic [7:0] b;
      b = 8'(i);
      if (i == 32'h10) return 32'hDEADBEEF;
      if (i == 32'h05) return 32'hFFFFFFFF;
      return {8'hA5, b, ~b, b ^ 8'h3C};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
      return r;
   endfunction

   // RAM attached to the DUT, 1-cycle read latency, with a one-cycle preload.
   logic [31:0] mem [256];
   logic        preload;
   int unsigned we_count;
   always @(posedge clk) begin
      if (preload) for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      else if (ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
      ram_rdata <= mem[ram_addr];
   end
   always @(posedge clk) begin
      if (preload)     we_count <= 0;
      else if (ram_we) we_count <= we_count + 1;
   end

   // Reference model state.
   logic [31:0] shadow [256];
   logic [7:0]  m_mona;
   logic [31:0] m_mond;
   bit          m_last_jtag;

   int total;
   int bad;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [37:0] mk_jdo(input int kind, input logic [7:0] a, input logic [31:0] d);
      logic [37:0] j;
      j = {6'($urandom), $urandom};
      case (kind)
         0, 1: j[9:2] = a;
         2: begin j[35] = 1'b1; j[31:0] = d; end
         default: j[35] = 1'b0;
      endcase
      return j;
   endfunction

   // kinds: 0 = action_a read at a, 1 = no_action_a re-read, 2 = b write d, 3 = b read
   task automatic strobe(input logic [2:0] mask, input logic [37:0] d);
      jdo = d;
      {take_action_ocimem_b, take_no_action_ocimem_a, take_action_ocimem_a} = mask;
      @(posedge clk); #1;
      {take_action_ocimem_b, take_no_action_ocimem_a, take_action_ocimem_a} = '0;
   endtask

   task automatic jtag_issue(input int kind, input logic [7:0] a, input logic [31:0] d);
      logic [2:0] mask;
      mask = (kind == 0) ? 3'b001 : (kind == 1) ? 3'b010 : 3'b100;
      strobe(mask, mk_jdo(kind, a, d));
   endtask

   task automatic model_jtag(input int kind, input logic [7:0] a, input logic [31:0] d);
      case (kind)
         0: begin m_mona = a; m_mond = shadow[m_mona]; end
         1: m_mond = shadow[m_mona];
         2: begin shadow[m_mona] = d; m_mona = m_mona + 8'd1; end
         default: begin m_mond = shadow[m_mona]; m_mona = m_mona + 8'd1; end
      endcase
      m_last_jtag = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!jtag_busy) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      chk({name, "_idle"}, 64'(ok), 64'd1);
   endtask

   task automatic jtag_check(input string name, input int kind, input logic [7:0] wa);
      chk({name, "_mona"}, MonAReg, m_mona);
      chk({name, "_mond"}, MonDReg, m_mond);
      if (kind == 2) chk({name, "_ram"}, mem[wa], shadow[wa]);
   endtask

   task automatic jtag_op(input int kind, input logic [7:0] a, input logic [31:0] d, input string name);
      logic [7:0] wa;
      wa = m_mona;
      jtag_issue(kind, a, d);
      model_jtag(kind, a, d);
      wait_idle(name);
      jtag_check(name, kind, wa);
   endtask

   task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, input int unsigned expw, input string name,
                         output logic [31:0] rd);
      int unsigned waits;
      bit          done;
      waits = 0;
      done  = 1'b0;
      rd    = '0;
      cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
      cpu_write = wr; cpu_read = !wr;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!cpu_waitrequest) begin rd = cpu_readdata; done = 1'b1; break; end
         waits++;
      end
      @(posedge clk); #1;
      cpu_read = 1'b0; cpu_write = 1'b0;
      m_last_jtag = 1'b0;
      chk({name, "_ack"}, 64'(done), 64'd1);
      chk({name, "_waits"}, 64'(waits), 64'(expw));
      if (wr) begin
         shadow[a] = merge(shadow[a], d, be);
         chk({name, "_ram"}, mem[a], shadow[a]);
      end else begin
         chk({name, "_rdata"}, rd, shadow[a]);
      end
   endtask

   // JTAG op pending while the CPU reads: the requester not served last goes first.
   task automatic contend(input int kind, input logic [7:0] ja, input logic [31:0] jd,
                          input logic [7:0] ca, input string name);
      bit          jfirst;
      int unsigned expw;
      logic [7:0]  wa;
      logic [31:0] rd;
      jfirst = !m_last_jtag;
      expw   = (jfirst ? ((kind == 2) ? 1 : 2) : 0) + 1;
      jtag_issue(kind, ja, jd);
      wa = m_mona;
      if (jfirst) model_jtag(kind, ja, jd);
      cpu_op(1'b0, ca, '0, '0, expw, name, rd);
      if (!jfirst) model_jtag(kind, ja, jd);
      wait_idle(name);
      jtag_check(name, kind, wa);
   endtask

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [9];

   initial begin
      logic [31:0] rd;
      logic [7:0]  wa;
      int unsigned we_before;
      int          nmis;

      vecs[0] = '{1'b1, 8'h40, 32'h11223344, 4'hF, 32'h11223344};
      vecs[1] = '{1'b1, 8'h40, 32'hAABBCCDD, 4'h4, 32'h11BB3344};
      vecs[2] = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h11BB3344};
      vecs[3] = '{1'b1, 8'h41, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
      vecs[4] = '{1'b1, 8'h41, 32'h00000000, 4'h9, 32'h00FEF000};
      vecs[5] = '{1'b0, 8'h41, 32'h0,        4'h0, 32'h00FEF000};
      vecs[6] = '{1'b1, 8'h42, 32'h01020304, 4'hF, 32'h01020304};
      vecs[7] = '{1'b1, 8'h42, 32'hFFFFFFFF, 4'h0, 32'h01020304};
      vecs[8] = '{1'b0, 8'h42, 32'h0,        4'h0, 32'h01020304};

      for (int i = 0; i < 256; i++) shadow[i] = pat(i);
      m_mona = '0; m_mond = '0; m_last_jtag = 1'b0;

      reset_n = 1'b0; preload = 1'b1; jdo = '0;
      take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
      cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0; cpu_byteenable = '0;
      @(posedge clk); #1;
      preload = 1'b0;
      @(negedge clk);
      chk("rst_waitreq", cpu_waitrequest, 1);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_mona", MonAReg, 0);
      chk("rst_mond", MonDReg, 0);
      chk("rst_busy", jtag_busy, 0);
      chk("rst_ovr", jtag_overrun, 0);
      chk("rst_rdata", cpu_readdata, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // action_a read at 0x10: busy for two cycles, data two cycles after the strobe.
      jtag_issue(0, 8'h10, '0);
      @(negedge clk);
      chk("a_mona", MonAReg, 8'h10);
      chk("a_busy1", jtag_busy, 1);
      chk("a_mond_early", MonDReg, 0);
      @(negedge clk);
      chk("a_busy2", jtag_busy, 1);
      @(negedge clk);
      chk("a_busy3", jtag_busy, 0);
      chk("a_mond", MonDReg, 32'hDEADBEEF);
      @(posedge clk); #1;
      model_jtag(0, 8'h10, '0);

      // b writes across the top of the address space.
      jtag_op(0, 8'hFE, '0, "ld_fe");
      jtag_op(2, '0, 32'd1, "bw1");
      jtag_op(2, '0, 32'd2, "bw2");
      jtag_op(2, '0, 32'd3, "bw3");
      chk("wrap_fe", mem[8'hFE], 32'd1);
      chk("wrap_ff", mem[8'hFF], 32'd2);
      chk("wrap_00", mem[8'h00], 32'd3);
      chk("wrap_mona", MonAReg, 8'h01);

      // CPU partial write, acknowledged in its request cycle.
      cpu_op(1'b1, 8'h05, 32'h12345678, 4'b0011, 0, "cpu_be", rd);
      chk("cpu_be_lit", mem[8'h05], 32'hFFFF5678);

      // JTAG read pending, last grant CPU: JTAG first, CPU data in cycle 4.
      contend(1, '0, '0, 8'h20, "cont");

      // Simultaneous a and b strobes: a wins, no write, no overrun.
      wa = 8'h31;
      strobe(3'b101, {2'b00, 1'b1, 3'b000, 32'h000000C0});
      model_jtag(0, 8'h30, '0);
      wait_idle("prio");
      jtag_check("prio", 0, 8'h30);
      chk("prio_nowr", mem[8'h30], shadow[8'h30]);
      chk("prio_ovr", jtag_overrun, 0);

      // Table vectors.
      for (int i = 0; i < 9; i++) begin
         cpu_op(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
                vecs[i].wr ? 0 : 1, $sformatf("vec%0d", i), rd);
         chk($sformatf("vec%0d_exp", i), vecs[i].wr ? mem[vecs[i].addr] : rd, vecs[i].exp);
      end
      jtag_op(0, 8'h41, '0, "vec_jtag");
      chk("vec_jtag_lit", MonDReg, 32'h00FEF000);

      // Overrun: b write one cycle after a b read strobe is dropped.
      wa = m_mona + 8'd1;
      jtag_issue(3, '0, '0);
      jtag_issue(2, '0, 32'h55555555);
      model_jtag(3, '0, '0);
      wait_idle("ovr");
      jtag_check("ovr", 3, '0);
      chk("ovr_flag", jtag_overrun, 1);
      chk("ovr_nowr", mem[wa], shadow[wa]);

      // Randomized mix.
      for (int i = 0; i < 40; i++) begin
         int          op;
         logic [7:0]  a;
         logic [31:0] d;
         op = $urandom_range(0, 6);
         a  = 8'($urandom);
         d  = $urandom;
         case (op)
            0: cpu_op(1'b1, a, d, 4'($urandom), 0, $sformatf("r%0d_cw", i), rd);
            1: cpu_op(1'b0, a, '0, '0, 1, $sformatf("r%0d_cr", i), rd);
            2, 3, 4, 5: jtag_op(op - 2, a, d, $sformatf("r%0d_j%0d", i, op - 2));
            default: contend($urandom_range(0, 3), a, d, 8'($urandom), $sformatf("r%0d_ct", i));
         endcase
      end
      nmis = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) nmis++;
      chk("mem_image", nmis, 0);
      chk("ovr_sticky", jtag_overrun, 1);

      // Reset asserted while the JTAG read is in its data cycle.
      jtag_issue(0, 8'h33, '0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      we_before = we_count;
      @(negedge clk);
      chk("mid_mond", MonDReg, 0);
      chk("mid_mona", MonAReg, 0);
      chk("mid_busy", jtag_busy, 0);
      chk("mid_waitreq", cpu_waitrequest, 1);
      chk("mid_ovr", jtag_overrun, 0);
      @(posedge clk); @(posedge clk); #1;
      chk("mid_nowrite", we_count, we_before);
      reset_n = 1'b1;
      m_mona = '0; m_mond = '0; m_last_jtag = 1'b0;
      cpu_op(1'b0, 8'h33, '0, '0, 1, "post_rst_cr", rd);
      jtag_op(3, '0, '0, "post_rst_br");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
